// File: rtl/csr_defs.sv
// csr_defs: shared definitions for the machine-mode CSR file.
//   - CSR address constants for every implemented (and optional) CSR
//   - access-operation encoding carried on op_i
//   - mstatus bit positions
//   - common mcause codes
//   - csr_wdata(): merges an operand into a CSR value according to the op
package csr_defs;

  // CSR addresses
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // Access operations
  typedef enum logic [1:0] {
    OP_RW  = 2'b00,
    OP_SET = 2'b01,
    OP_CLR = 2'b10,
    OP_RO  = 2'b11
  } csr_op_e;

  // mstatus fields
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // mcause codes (exceptions)
  localparam logic [31:0] CAUSE_INSN_MISALIGNED = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL_INSN    = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT      = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M         = 32'd11;

  // Value a write would leave in the CSR, before any WARL masking.
  function automatic logic [31:0] csr_wdata(input csr_op_e op,
                                            input logic [31:0] cur,
                                            input logic [31:0] operand);
    case (op)
      OP_RW:   csr_wdata = operand;
      OP_SET:  csr_wdata = cur | operand;
      OP_CLR:  csr_wdata = cur & ~operand;
      default: csr_wdata = cur;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// csr_counter: free-running W-bit counter exposed as two 32-bit CSR halves.
//   clk    in   clock
//   rst_n  in   async reset, active low (clears the count)
//   inc    in   add one this cycle
//   wr_lo  in   replace bits [31:0] with wdata (wins over inc)
//   wr_hi  in   replace bits [W-1:32] with wdata (wins over inc)
//   wdata  in   32-bit write value
//   value  out  count zero-extended to 64 bits
// Legal W is 32..64; bits at and above W always read 0 and wrap is natural.
module csr_counter #(
  parameter int W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [W-1:0] cnt_q;
  logic [63:0]  cnt_ext;
  logic [63:0]  merged;

  assign cnt_ext = 64'(cnt_q);
  assign value   = cnt_ext;

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    merged = cnt_ext;
    if (wr_lo) merged[31:0]  = wdata;
    if (wr_hi) merged[63:32] = wdata;
  end

  // A half write replaces the count outright; the increment for that cycle is lost.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (wr_lo || wr_hi) begin
      cnt_q <= merged[W-1:0];
    end else if (inc) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Bits of the merged word beyond the counter width are discarded.
  generate
    if (W < 64) begin : g_narrow
      logic unused_merged;
      assign unused_merged = ^merged[63:W];
    end
  endgenerate

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with trap entry/return support.
//   clk_i, rst_ni           clock, async active-low reset
//   addr_i, data_i, op_i    CSR address, operand, op (RW/set/clear/read-only)
//   we_i                    access carries write intent
//   data_o, illegal_o       combinational read value / illegal-access flag
//   instret_inc_i           one instruction retired (used only with CSR_INSTRET_EN)
//   trap_i, trap_pc_i,      trap entry pulse with faulting PC and cause
//   trap_cause_i
//   mret_i                  trap return pulse
//   mtvec_o, mepc_o, mie_o  direct register views of mtvec, mepc, mstatus.MIE
// Optional feature: define CSR_INSTRET_EN to add minstret/minstreth and the
// instret/instreth user aliases.
module csr_file
  import csr_defs::*;
#(
  parameter logic [31:0] VEND_ID   = 32'h0,
  parameter logic [31:0] ARCH_ID   = 32'h0,
  parameter logic [31:0] IMPL_ID   = 32'h0,
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter int          COUNTER_W = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [11:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  op_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        illegal_o,
  input  logic        instret_inc_i,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  logic        mie_q, mpie_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle, minstret;
  logic [31:0] mstatus_rd;
  logic [31:0] wval;
  logic        implemented;
  logic        wr_en;

  assign mstatus_rd = (32'(mie_q) << MSTATUS_MIE) | (32'(mpie_q) << MSTATUS_MPIE);

  // Read mux; anything not listed is unimplemented and reads 0.
  always_comb begin
    data_o      = '0;
    implemented = 1'b1;
    case (addr_i)
      CSR_MVENDORID:           data_o = VEND_ID;
      CSR_MARCHID:             data_o = ARCH_ID;
      CSR_MIMPID:              data_o = IMPL_ID;
      CSR_MHARTID:             data_o = HART_ID;
      CSR_MSTATUS:             data_o = mstatus_rd;
      CSR_MTVEC:               data_o = mtvec_q;
      CSR_MSCRATCH:            data_o = mscratch_q;
      CSR_MEPC:                data_o = mepc_q;
      CSR_MCAUSE:              data_o = mcause_q;
      CSR_MCYCLE, CSR_CYCLE:   data_o = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH: data_o = mcycle[63:32];
`ifdef CSR_INSTRET_EN
      CSR_MINSTRET, CSR_INSTRET:   data_o = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: data_o = minstret[63:32];
`endif
      default:                 implemented = 1'b0;
    endcase
  end

  // addr[11:10]==2'b11 marks the read-only CSR space; op 11 never writes.
  assign illegal_o = !implemented ||
                     (we_i && (addr_i[11:10] == 2'b11) && (op_i != OP_RO));
  assign wr_en     = we_i && (op_i != OP_RO) && !illegal_o;
  assign wval      = csr_wdata(csr_op_e'(op_i), data_o, data_i);

  csr_counter #(.W(COUNTER_W)) u_mcycle (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (1'b1),
    .wr_lo (wr_en && (addr_i == CSR_MCYCLE)),
    .wr_hi (wr_en && (addr_i == CSR_MCYCLEH)),
    .wdata (wval),
    .value (mcycle)
  );

`ifdef CSR_INSTRET_EN
  csr_counter #(.W(COUNTER_W)) u_minstret (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (instret_inc_i),
    .wr_lo (wr_en && (addr_i == CSR_MINSTRET)),
    .wr_hi (wr_en && (addr_i == CSR_MINSTRETH)),
    .wdata (wval),
    .value (minstret)
  );
`else
  assign minstret = '0;
  logic unused_instret;
  assign unused_instret = instret_inc_i ^ (^minstret);
`endif

  // mstatus: trap entry beats mret, and either beats a software write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
    end else if (trap_i) begin
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
    end else if (mret_i) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (wr_en && (addr_i == CSR_MSTATUS)) begin
      mie_q  <= wval[MSTATUS_MIE];
      mpie_q <= wval[MSTATUS_MPIE];
    end
  end

  // mepc/mcause: a trap overrides any software write in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (trap_i) begin
      mepc_q   <= trap_pc_i & ~32'h3;
      mcause_q <= trap_cause_i;
    end else if (wr_en) begin
      if (addr_i == CSR_MEPC)   mepc_q   <= wval & ~32'h3;
      if (addr_i == CSR_MCAUSE) mcause_q <= wval;
    end
  end

  // mtvec keeps bit 1 clear so only direct/vectored modes are representable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtvec_q    <= MTVEC_RST & ~32'h2;
      mscratch_q <= '0;
    end else if (wr_en) begin
      if (addr_i == CSR_MTVEC)    mtvec_q    <= wval & ~32'h2;
      if (addr_i == CSR_MSCRATCH) mscratch_q <= wval;
    end
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = mie_q;

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter VEND_ID, default 32'h0, mvendorid value.
REQ-002 SHALL have parameter ARCH_ID, default 32'h0, marchid value.
REQ-003 SHALL have parameter IMPL_ID, default 32'h0, mimpid value.
REQ-004 SHALL have parameter HART_ID, default 32'h0, mhartid value.
REQ-005 SHALL have parameter COUNTER_W, default 64, counter width, legal range 32..64.
REQ-006 SHALL have parameter MTVEC_RST, default 32'h0, mtvec reset value.
REQ-007 SHALL have a single clock, clk_i, and an asynchronous active-low reset, rst_ni.
REQ-008 Ports (all SHALL exist):
- clk_i  in  1  clock.
- rst_ni  in  1  async reset, active low.
- addr_i  in  12  CSR address.
- data_i  in  32  write operand.
- op_i  in  2  00 RW, 01 set, 10 clear, 11 read-only.
- we_i  in  1  access request with write intent.
- data_o  out  32  current CSR value, combinational.
- illegal_o  out  1  access illegal, combinational.
- instret_inc_i  in  1  one instruction retired.
- trap_i  in  1  trap entry pulse.
- trap_pc_i  in  32  PC of trapping instruction.
- trap_cause_i  in  32  cause code.
- mret_i  in  1  trap return pulse.
- mtvec_o  out  32  mtvec register.
- mepc_o  out  32  mepc register.
- mie_o  out  1  mstatus.MIE.

Function
REQ-009 Implemented CSRs SHALL be: mvendorid F11, marchid F12, mimpid F13, mhartid F14, mstatus 300 (MIE bit 3, MPIE bit 7, other bits read 0), mtvec 305, mscratch 340, mepc 341, mcause 342, mcycle/mcycleh B00/B80, cycle/cycleh C00/C80.
REQ-010 Write value SHALL be: RW data_i; set read|data_i; clear read&~data_i; op 11 no write.
REQ-011 illegal_o SHALL assert for an unimplemented addr_i, or for we_i with addr_i[11:10]==2'b11 and op_i!=11; it SHALL NOT assert otherwise.
REQ-012 A write SHALL commit at the next rising clk_i when we_i=1, op_i!=11, and illegal_o=0; illegal accesses SHALL change no state; unimplemented reads SHALL return 32'h0.
REQ-013 data_o SHALL show the pre-write value in the cycle of the write.
REQ-014 mcycle SHALL increment by 1 every cycle, wrap 2^COUNTER_W-1 -> 0; bits at and above COUNTER_W SHALL read 0; cycle/cycleh SHALL alias mcycle/mcycleh.
REQ-015 A write to mcycle or mcycleh SHALL replace that half and suppress the increment in that cycle.
REQ-016 mepc bits[1:0] SHALL always read 0; mtvec[1] SHALL always read 0 (WARL, modes 0/1 only).
REQ-017 trap_i SHALL, next edge: mepc<=trap_pc_i&~3, mcause<=trap_cause_i, MPIE<=MIE, MIE<=0.
REQ-018 mret_i SHALL, next edge: MIE<=MPIE, MPIE<=1.
REQ-019 trap_i and mret_i together SHALL apply trap_i only.
REQ-020 trap_i together with a CSR write to mstatus/mepc/mcause SHALL apply the trap and drop that write; writes to other CSRs SHALL commit.
REQ-021 mtvec_o, mepc_o, and mie_o SHALL be register outputs with zero added latency.

Reset
REQ-022 While rst_ni=0, counters, mstatus, mscratch, mepc, and mcause SHALL be 0, and mtvec SHALL be MTVEC_RST.
REQ-023 Reset SHALL take effect immediately and asynchronously, including mid-write; release SHALL be synchronous to clk_i by the integrator.

Configuration
REQ-024 Macro CSR_INSTRET_EN defined SHALL add minstret/minstreth B02/B82 and instret/instreth C02/C82, COUNTER_W wide, incrementing on instret_inc_i, with REQ-014/015 wrap and write-priority rules.
REQ-025 Without CSR_INSTRET_EN, those addresses SHALL be unimplemented (illegal_o=1, read 0), and instret_inc_i SHALL be ignored.

Structure
REQ-026 The shared package csr_defs SHALL hold CSR address constants, op_i encodings, mstatus bit positions, and cause codes.
REQ-027 One sub-module, csr_counter (parameter W), SHALL implement increment, wrap, and split 32-bit half writes; it SHALL be instanced for mcycle and, when enabled, minstret.

Verification
REQ-028 The bench SHALL cover: reset, then 10 cycles idle -> read C00 returns 10; read F14 with HART_ID=5 returns 5.
REQ-029 The bench SHALL cover: mscratch RW 0xA5A5_0F0F, set 0x0000_00F0, clear 0x0000_000F -> reads 0xA5A5_0FF0.
REQ-030 The bench SHALL cover: COUNTER_W=33, write mcycle=FFFF_FFFF, mcycleh=1 -> two cycles later reads 0x0000_0001 and mcycleh 0.
REQ-031 The bench SHALL cover: write C00 with we_i -> illegal_o=1, cycle unaffected; read 0x7C0 -> illegal_o=1, data_o 0.
REQ-032 The bench SHALL cover: MIE=1, trap_i with pc 0x8000_0006 and cause 0xB, concurrent mret_i -> mepc 0x8000_0004, mcause 0xB, MIE 0, MPIE 1; then mret_i -> MIE 1.
REQ-033 The bench SHALL cover: rst_ni low mid-write of mtvec 0x100 with MTVEC_RST 0x80 -> mtvec_o 0x80 without a clock edge.
